// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: control-bundle bit
// positions, the NOP encoding and the payload field layout.
package ex_mem_pkg;

    // Control bundle, MSB first: MR, MW, MemtoReg, jmp, beq, bneq, bge, blt, regWE
    localparam int CTRL_W        = 9;
    localparam int CTRL_MR       = 8;
    localparam int CTRL_MW       = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_JMP      = 5;
    localparam int CTRL_BEQ      = 4;
    localparam int CTRL_BNEQ     = 3;
    localparam int CTRL_BGE      = 2;
    localparam int CTRL_BLT      = 1;
    localparam int CTRL_REGWE    = 0;

    // An all-zero control bundle does nothing downstream
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // Payload = {alu_result, rout2, pc}
    localparam int FIELD_W = 32;
    localparam int DATA_W  = 3 * FIELD_W;
    localparam int ALU_LSB = 2 * FIELD_W;
    localparam int RS2_LSB = FIELD_W;
    localparam int PC_LSB  = 0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready buffer. The main entry drives the outputs;
// the skid entry catches one beat while the main entry is held, which lets
// in_ready come straight from a flop and still sustain one beat per cycle.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);
    import ex_mem_pkg::*;

    logic         m_vld_q, m_vld_d;
    logic [W-1:0] m_dat_q, m_dat_d;
    logic         s_vld_q, s_vld_d;
    logic [W-1:0] s_dat_q, s_dat_d;
    logic         in_fire, out_fire;

    assign in_ready  = ~s_vld_q;
    assign in_fire   = in_valid & ~s_vld_q;
    assign out_fire  = m_vld_q & out_ready;
    assign out_valid = m_vld_q;
    assign out_data  = m_dat_q;
    assign occupancy = {1'b0, m_vld_q} + {1'b0, s_vld_q};

    // Next-state: skid is only ever full while main is full, so an empty
    // main always loads straight from the input. Flush overrides every load.
    always_comb begin
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (out_fire) begin
            if (s_vld_q) begin
                m_dat_d = s_dat_q;
                s_vld_d = 1'b0;
            end else if (in_fire) begin
                m_dat_d = in_data;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            if (m_vld_q) begin
                s_vld_d = 1'b1;
                s_dat_d = in_data;
            end else begin
                m_vld_d = 1'b1;
                m_dat_d = in_data;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_vld_q <= 1'b0;
            m_dat_q <= '0;
            s_vld_q <= 1'b0;
            s_dat_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            m_dat_q <= m_dat_d;
            s_vld_q <= s_vld_d;
            s_dat_q <= s_dat_d;
        end
    end

endmodule

// File: rtl/ex_mem_elastic_stage.sv
// EX->MEM pipeline stage with valid/ready flow control, flush, optional
// skid buffer and a saturating stall-cycle counter. An empty stage presents
// a NOP (ctrl and rd masked to zero) to MEM and the hazard logic.
module ex_mem_elastic_stage #(
    parameter int CTRL_W = ex_mem_pkg::CTRL_W,
    parameter int RD_W   = 5,
    parameter int DATA_W = ex_mem_pkg::DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt
);
    import ex_mem_pkg::*;

    localparam int W = CTRL_W + RD_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [W-1:0]     in_bus, out_bus;
    logic             out_vld;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_bus = {in_ctrl, in_rd, in_data};

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(.W(W)) u_buf (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (in_bus),
                .out_valid (out_vld),
                .out_ready (out_ready),
                .out_data  (out_bus),
                .occupancy (occupancy)
            );
        end else begin : g_reg
            logic         m_vld_q, m_vld_d;
            logic [W-1:0] m_bus_q, m_bus_d;
            logic         in_fire;

            assign in_ready = out_ready | ~m_vld_q;
            assign in_fire  = in_valid & in_ready;

            // Single register: load on accept, drain when consumed, flush wins
            always_comb begin
                m_vld_d = m_vld_q;
                m_bus_d = m_bus_q;
                if (flush) begin
                    m_vld_d = 1'b0;
                end else if (in_fire) begin
                    m_vld_d = 1'b1;
                    m_bus_d = in_bus;
                end else if (out_ready) begin
                    m_vld_d = 1'b0;
                end
            end

            // Register with synchronous active-low reset
            always_ff @(posedge clk) begin
                if (!rst) begin
                    m_vld_q <= 1'b0;
                    m_bus_q <= '0;
                end else begin
                    m_vld_q <= m_vld_d;
                    m_bus_q <= m_bus_d;
                end
            end

            assign out_vld   = m_vld_q;
            assign out_bus   = m_bus_q;
            assign occupancy = {1'b0, m_vld_q};
        end
    endgenerate

    assign out_valid = out_vld;
    assign out_ctrl  = out_vld ? out_bus[W-1 -: CTRL_W] : CTRL_W'(CTRL_NOP);
    assign out_rd    = out_vld ? out_bus[DATA_W +: RD_W] : '0;
    assign out_data  = out_bus[DATA_W-1:0];

    // Stall counter looks at the pre-flush output state; clear beats increment
    assign stall = out_vld & ~out_ready;
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr)
            stall_cnt_d = '0;
        else if (stall && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// Directed bench for ex_mem_elastic_stage: one skid build and one
// single-register build, both with a 4-bit stall counter.
module tb_ex_mem_elastic_stage;

    logic        clk;
    logic        rst, flush, perf_clr, out_ready;
    logic        iv_s, iv_r;
    logic [8:0]  in_ctrl;
    logic [4:0]  in_rd;
    logic [95:0] in_data;

    logic        s_ov, s_ird, r_ov, r_ird;
    logic [8:0]  s_ctrl, r_ctrl;
    logic [4:0]  s_rd, r_rd;
    logic [95:0] s_data, r_data;
    logic [1:0]  s_occ, r_occ;
    logic [3:0]  s_cnt, r_cnt;

    bit          sel;
    logic        o_ov, o_ird;
    logic [8:0]  o_ctrl;
    logic [4:0]  o_rd;
    logic [95:0] o_data;
    logic [1:0]  o_occ;

    int n_chk = 0;
    int n_err = 0;

    ex_mem_elastic_stage #(.CTRL_W(9), .RD_W(5), .DATA_W(96), .SKID(1), .CNT_W(4)) u_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv_s), .in_ready(s_ird),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
        .out_valid(s_ov), .out_ready(out_ready), .out_ctrl(s_ctrl), .out_rd(s_rd),
        .out_data(s_data), .occupancy(s_occ), .perf_clr(perf_clr), .stall_cnt(s_cnt)
    );

    ex_mem_elastic_stage #(.CTRL_W(9), .RD_W(5), .DATA_W(96), .SKID(0), .CNT_W(4)) u_r (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv_r), .in_ready(r_ird),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
        .out_valid(r_ov), .out_ready(out_ready), .out_ctrl(r_ctrl), .out_rd(r_rd),
        .out_data(r_data), .occupancy(r_occ), .perf_clr(perf_clr), .stall_cnt(r_cnt)
    );

    assign o_ov   = sel ? r_ov   : s_ov;
    assign o_ird  = sel ? r_ird  : s_ird;
    assign o_ctrl = sel ? r_ctrl : s_ctrl;
    assign o_rd   = sel ? r_rd   : s_rd;
    assign o_data = sel ? r_data : s_data;
    assign o_occ  = sel ? r_occ  : s_occ;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] mk_ctrl(input int k);
        return 9'h100 | 9'(k);
    endfunction

    function automatic logic [4:0] mk_rd(input int k);
        return 5'(k + 1);
    endfunction

    function automatic logic [95:0] mk_data(input int k);
        return {32'(k + 32'hA000), 32'(k + 32'hB000), 32'(k * 4)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check the visible state, advance past the edge
    task automatic cyc(input string tag, input bit iv, input int k, input bit ord, input bit fl,
                       input bit eov, input int ek, input int eocc, input bit eird);
        if (sel) begin iv_r = iv; iv_s = 1'b0; end
        else     begin iv_s = iv; iv_r = 1'b0; end
        in_ctrl   = mk_ctrl(k);
        in_rd     = mk_rd(k);
        in_data   = mk_data(k);
        out_ready = ord;
        flush     = fl;
        #1;
        chk({tag, ".ov"},   o_ov,   eov);
        chk({tag, ".ctrl"}, o_ctrl, eov ? mk_ctrl(ek) : 9'd0);
        chk({tag, ".rd"},   o_rd,   eov ? mk_rd(ek)   : 5'd0);
        if (eov) chk({tag, ".data"}, o_data, mk_data(ek));
        chk({tag, ".occ"},  o_occ,  eocc);
        chk({tag, ".ird"},  o_ird,  eird);
        @(posedge clk); #1;
    endtask

    task automatic stream(input string pfx);
        for (int i = 0; i <= 8; i++)
            cyc($sformatf("%s%0d", pfx, i), i < 8, i, 1'b1, 1'b0, i > 0, i - 1, (i > 0) ? 1 : 0, 1'b1);
        cyc({pfx, "end"}, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        sel = 1'b0; rst = 1'b0; flush = 1'b0; perf_clr = 1'b0; out_ready = 1'b0;
        iv_s = 1'b1; iv_r = 1'b1;
        in_ctrl = mk_ctrl(5); in_rd = mk_rd(5); in_data = mk_data(5);

        // Reset held with valid input present
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst.s_ov", s_ov, 0);   chk("rst.s_ctrl", s_ctrl, 0);
            chk("rst.s_occ", s_occ, 0); chk("rst.s_cnt", s_cnt, 0);
            chk("rst.r_ov", r_ov, 0);   chk("rst.r_ctrl", r_ctrl, 0);
            chk("rst.r_occ", r_occ, 0); chk("rst.r_cnt", r_cnt, 0);
        end
        rst = 1'b1; iv_s = 1'b0; iv_r = 1'b0;
        @(posedge clk); #1;
        chk("rst.s_ird", s_ird, 1);
        chk("rst.r_ird", r_ird, 1);

        // ---- skid build ----
        stream("s_str");

        cyc("s_bp0", 1, 10, 1, 0, 0, 0,  0, 1);
        cyc("s_bp1", 1, 11, 0, 0, 1, 10, 1, 1);
        cyc("s_bp2", 1, 12, 0, 0, 1, 10, 2, 0);
        cyc("s_bp3", 1, 12, 0, 0, 1, 10, 2, 0);
        chk("s_bp.stall", s_cnt, 3);
        cyc("s_bp4", 1, 12, 1, 0, 1, 10, 2, 0);
        cyc("s_bp5", 1, 12, 1, 0, 1, 11, 1, 1);
        cyc("s_bp6", 0, 0,  1, 0, 1, 12, 1, 1);
        cyc("s_bp7", 0, 0,  1, 0, 0, 0,  0, 1);
        chk("s_bp.stall2", s_cnt, 3);

        // Flush with both entries held, then flush with a coincident accept
        cyc("s_fl0", 1, 20, 1, 0, 0, 0,  0, 1);
        cyc("s_fl1", 1, 21, 0, 0, 1, 20, 1, 1);
        cyc("s_fl2", 1, 22, 0, 1, 1, 20, 2, 0);
        cyc("s_fl3", 1, 23, 1, 0, 0, 0,  0, 1);
        cyc("s_fl4", 1, 24, 0, 1, 1, 23, 1, 1);
        cyc("s_fl5", 0, 0,  1, 0, 0, 0,  0, 1);
        cyc("s_fl6", 0, 0,  1, 0, 0, 0,  0, 1);

        // Counter: clear, saturate, clear while stalled
        chk("cnt.pre", s_cnt, 6);
        perf_clr = 1'b1; @(posedge clk); #1; perf_clr = 1'b0;
        chk("cnt.clr0", s_cnt, 0);
        cyc("cnt.ld", 1, 30, 1, 0, 0, 0, 0, 1);
        iv_s = 1'b0; out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("cnt.sat", s_cnt, 15);
        chk("cnt.hold", s_data, mk_data(30));
        perf_clr = 1'b1; @(posedge clk); #1; perf_clr = 1'b0;
        chk("cnt.clr", s_cnt, 0);
        @(posedge clk); #1;
        chk("cnt.restart", s_cnt, 1);

        // ---- single-register build; reset drops the held skid entry ----
        sel = 1'b1;
        rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
        chk("mid.s_ov", s_ov, 0);   chk("mid.s_occ", s_occ, 0);
        chk("mid.s_cnt", s_cnt, 0); chk("mid.r_cnt", r_cnt, 0);

        stream("r_str");

        cyc("r_bp0", 1, 10, 1, 0, 0, 0,  0, 1);
        cyc("r_bp1", 1, 11, 0, 0, 1, 10, 1, 0);
        cyc("r_bp2", 1, 11, 0, 0, 1, 10, 1, 0);
        cyc("r_bp3", 1, 11, 0, 0, 1, 10, 1, 0);
        chk("r_bp.stall", r_cnt, 3);
        cyc("r_bp4", 1, 11, 1, 0, 1, 10, 1, 1);
        cyc("r_bp5", 1, 12, 1, 0, 1, 11, 1, 1);
        cyc("r_bp6", 0, 0,  1, 0, 1, 12, 1, 1);
        cyc("r_bp7", 0, 0,  1, 0, 0, 0,  0, 1);

        cyc("r_fl0", 1, 40, 0, 0, 0, 0,  0, 1);
        cyc("r_fl1", 1, 41, 0, 1, 1, 40, 1, 0);
        cyc("r_fl2", 0, 0,  1, 0, 0, 0,  0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
